data_mem_responder: RTL
=======================

// Module: data_mem_responder
// PURPOSE
//  Responder end of the CPU data-memory port: word RAM plus a small MMIO window.
//  Loads are combinational, so a single-cycle CPU reads in the same cycle; stores commit on clk.
//  MMIO carries a byte console TX FIFO, drained to the host or bench over a valid/ready stream,
//  plus status/overflow and an optional free-running cycle counter.
// PARAMETERS
//  RAM_WORDS   1024           RAM depth in 32-bit words; power of 2; mapped at word addr 0.
//  FIFO_DEPTH  8              console FIFO depth in bytes; power of 2, >=2.
//  MMIO_BASE   30'h3FFFFFC0   word address of MMIO window (16 words); must not overlap RAM.
// PORTS
//  clk                    in   1   clock; all state updates on rising edge
//  rst                    in   1   synchronous reset, active-high
//  data_mem_addr          in   30  word address from CPU
//  data_mem_write_enable  in   1   store strobe; commits at next rising clk edge
//  data_mem_write_data    in   32  store data
//  data_mem_read_data     out  32  load data, combinational from addr and current state
//  tx_valid               out  1   FIFO head byte available
//  tx_data                out  8   FIFO head byte; held stable while tx_valid && !tx_ready
//  tx_ready               in   1   consumer accepts; pop when tx_valid && tx_ready at edge
// BEHAVIOUR
//  Decode: RAM when addr < RAM_WORDS; MMIO when addr[29:4]==MMIO_BASE[29:4] (offset addr[3:0]).
//   Anything else: read 32'h0, write ignored.
//  RAM: store writes word at addr[$clog2(RAM_WORDS)-1:0]; contents not reset; no byte enables.
//  MMIO map (word offsets):
//   0 TX_DATA  W: push write_data[7:0]. R: 0.
//   1 STATUS   R: [0]empty [1]full [2]overflow [15:8]count, rest 0.
//              W: write_data[2]=1 clears overflow; other bits ignored.
//   2 CYCLE    R: cycle counter. W: ignored.
//   3..15      R: 0. W: ignored.
//  FIFO: circular buffer, rd/wr pointers wrap modulo FIFO_DEPTH, count 0..FIFO_DEPTH.
//   tx_valid = (count != 0); tx_data = buf[rd_ptr].
//   Pop: on tx_valid && tx_ready.
//   Push: TX_DATA write when !full, OR when full and a pop occurs in the same cycle.
//     Push+pop same cycle: count unchanged, both pointers advance.
//   Push while full with no pop: byte dropped, overflow<=1 (sticky).
//   Overflow set and clear in the same cycle: set wins.
//   Empty + push: byte visible on tx_data the cycle after the edge (1-cycle latency).
//  Reset (rst high at edge): count=0, pointers=0, overflow=0, cycle=0 -> tx_valid=0.
//   During the reset cycle a store still commits to RAM, but FIFO/status stores are discarded.
//   Reset mid-drain discards queued bytes; the stream restarts empty.
//  Read mux is purely combinational. A read of STATUS returns pre-edge state, even if the
//   same cycle has a write to it.
// CONFIGURATION
//  DATA_MEM_CYCLE_COUNTER_EN defined:
//   32-bit counter, 0 after rst, +1 every non-reset cycle, wraps 32'hFFFFFFFF->0;
//   CYCLE reads its value.
//  Undefined: no counter flops; CYCLE reads 32'h0.
// STRUCTURE
//  Package data_mem_pkg:
//   MMIO offset localparams (TX_DATA=0, STATUS=1, CYCLE=2);
//   STATUS bit indices (EMPTY=0, FULL=1, OVF=2, CNT_LSB=8).
//  Sub-module byte_fifo (params DEPTH, WIDTH=8): push/pop/full/empty/count, sync reset.
//   Top = address decode, RAM array, status/overflow logic, counter, read mux.
// TESTING
//  1 Store 32'hDEADBEEF @ addr 5, then load addr 5 -> read_data=32'hDEADBEEF same cycle as addr.
//  2 tx_ready=0; write 'A','B','C' to TX_DATA -> STATUS count=3, tx_data='A';
//    raise tx_ready -> 'A','B','C' on consecutive cycles, then tx_valid=0, empty=1.
//  3 tx_ready=0; push 9 bytes (DEPTH 8) -> full=1, overflow=1, 9th byte lost;
//    write STATUS 32'h4 -> overflow=0, full still 1.
//  4 Full FIFO, tx_ready=1 plus TX_DATA write same cycle -> accepted, count stays 8, no overflow.
//  5 Fill 5 bytes, assert rst one cycle -> tx_valid=0, count=0, overflow=0; RAM data preserved.
//  6 With _EN: rst, 10 idle cycles -> CYCLE reads 10. Without: reads 0.
//    Unmapped addr 30'h00100000 -> reads 0; a store there changes no observable state.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared constants for the data-memory responder: MMIO word offsets, STATUS bit layout
// and the address-region type used by the decoder.
package data_mem_pkg;

    localparam logic [3:0] MMIO_TX_DATA = 4'd0;
    localparam logic [3:0] MMIO_STATUS  = 4'd1;
    localparam logic [3:0] MMIO_CYCLE   = 4'd2;

    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        REGION_NONE,
        REGION_RAM,
        REGION_MMIO
    } region_e;

    function automatic logic [31:0] pack_status(input logic       empty,
                                                input logic       full,
                                                input logic       ovf,
                                                input logic [7:0] count);
        logic [31:0] s;
        s                      = '0;
        s[STAT_EMPTY]          = empty;
        s[STAT_FULL]           = full;
        s[STAT_OVF]            = ovf;
        s[STAT_CNT_LSB +: 8]   = count;
        return s;
    endfunction

endpackage

// File: rtl/byte_fifo.sv
// Circular-buffer FIFO with synchronous reset. A push into a full FIFO is accepted
// only when a pop happens in the same cycle; otherwise the caller sees it rejected.
module byte_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] buf_reg [DEPTH];
    logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
    logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count_reg == CNT_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign rd_data = buf_reg[rd_ptr_reg];

    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        rd_ptr_next = rd_ptr_reg;
        wr_ptr_next = wr_ptr_reg;
        count_next  = count_reg;
        // DEPTH is a power of two, so pointer overflow is the modulo wrap
        if (pop_ok)  rd_ptr_next = rd_ptr_reg + 1'b1;
        if (push_ok) wr_ptr_next = wr_ptr_reg + 1'b1;
        case ({push_ok, pop_ok})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            rd_ptr_reg <= rd_ptr_next;
            wr_ptr_reg <= wr_ptr_next;
            count_reg  <= count_next;
        end
    end

    // Storage is not reset; only entries between the pointers are ever observed.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push_ok && (wr_ptr_reg == PTR_W'(gi)))
                buf_reg[gi] <= push_data;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// CPU data-memory responder: word RAM with combinational loads, plus an MMIO window with
// a console TX FIFO, status/overflow and an optional cycle counter (DATA_MEM_CYCLE_COUNTER_EN).
module data_mem_responder
    import data_mem_pkg::*;
#(
    parameter int          RAM_WORDS  = 1024,
    parameter int          FIFO_DEPTH = 8,
    parameter logic [29:0] MMIO_BASE  = 30'h3FFFFFC0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [29:0] data_mem_addr,
    input  logic        data_mem_write_enable,
    input  logic [31:0] data_mem_write_data,
    output logic [31:0] data_mem_read_data,
    output logic        tx_valid,
    output logic [7:0]  tx_data,
    input  logic        tx_ready
);

    localparam int RAM_AW = $clog2(RAM_WORDS);
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    region_e           region;
    logic [3:0]        mmio_offset;
    logic [RAM_AW-1:0] ram_idx;
    logic              ram_we;
    logic              mmio_we;
    logic              tx_push;
    logic              tx_pop;
    logic              ovf_clear;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CNT_W-1:0]  fifo_count;
    logic              ovf_reg, ovf_next;
    logic [31:0]       cycle_value;
    logic [31:0]       ram_mem [RAM_WORDS];

    always_comb begin
        region = REGION_NONE;
        if (data_mem_addr < 30'(RAM_WORDS))
            region = REGION_RAM;
        else if (data_mem_addr[29:4] == MMIO_BASE[29:4])
            region = REGION_MMIO;
    end

    assign mmio_offset = data_mem_addr[3:0];
    assign ram_idx     = data_mem_addr[RAM_AW-1:0];

    // RAM stores are deliberately not gated by rst; MMIO side effects are.
    assign ram_we  = data_mem_write_enable && (region == REGION_RAM);
    assign mmio_we = data_mem_write_enable && (region == REGION_MMIO) && !rst;

    assign tx_push   = mmio_we && (mmio_offset == MMIO_TX_DATA);
    assign ovf_clear = mmio_we && (mmio_offset == MMIO_STATUS) && data_mem_write_data[STAT_OVF];
    assign tx_pop    = tx_valid && tx_ready;
    assign tx_valid  = !fifo_empty;

    always_ff @(posedge clk) begin
        if (ram_we)
            ram_mem[ram_idx] <= data_mem_write_data;
    end

    byte_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_tx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (tx_push),
        .push_data (data_mem_write_data[7:0]),
        .pop       (tx_pop),
        .rd_data   (tx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // A dropped push sets overflow even if the same cycle asks to clear it.
    always_comb begin
        ovf_next = ovf_reg;
        if (ovf_clear)
            ovf_next = 1'b0;
        if (tx_push && fifo_full && !tx_pop)
            ovf_next = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            ovf_reg <= 1'b0;
        else
            ovf_reg <= ovf_next;
    end

`ifdef DATA_MEM_CYCLE_COUNTER_EN
    logic [31:0] cycle_reg;

    always_ff @(posedge clk) begin
        if (rst)
            cycle_reg <= '0;
        else
            cycle_reg <= cycle_reg + 32'd1;
    end

    assign cycle_value = cycle_reg;
`else
    assign cycle_value = '0;
`endif

    always_comb begin
        data_mem_read_data = '0;
        case (region)
            REGION_RAM: data_mem_read_data = ram_mem[ram_idx];
            REGION_MMIO: begin
                case (mmio_offset)
                    MMIO_STATUS: data_mem_read_data = pack_status(fifo_empty, fifo_full,
                                                                  ovf_reg, 8'(fifo_count));
                    MMIO_CYCLE:  data_mem_read_data = cycle_value;
                    default:     data_mem_read_data = '0;
                endcase
            end
            default: data_mem_read_data = '0;
        endcase
    end

endmodule
